// File: rtl/gpr_file_pkg.sv
// Shared index constants, write-select encodings and write-qualify helper
// for the gpr_file register file.
package gpr_file_pkg;

  localparam int GPR_IDX_ZERO = 0;
  localparam int GPR_IDX_OF   = 30;
  localparam int GPR_IDX_RA   = 31;

  typedef enum logic [1:0] {
    GPR_WRITE_ADDR_RT = 2'd0,
    GPR_WRITE_ADDR_RD = 2'd1,
    GPR_WRITE_ADDR_RA = 2'd2
  } gpr_waddr_sel_e;

  typedef enum logic [1:0] {
    GPR_WRITE_ALU = 2'd0,
    GPR_WRITE_MEM = 2'd1,
    GPR_WRITE_PC4 = 2'd2
  } gpr_wdata_sel_e;

  typedef struct packed {
    logic commit;
    logic of_set;
  } gpr_wq_t;

  function automatic gpr_wq_t gpr_write_qual(
    input logic we,
    input logic of_en,
    input logic ovf,
    input logic addr_nz
  );
    gpr_wq_t q;
    q.commit = we & addr_nz & ~(of_en & ovf);
    q.of_set = we & addr_nz & of_en & ovf;
    return q;
  endfunction

endpackage

// File: rtl/gpr_file_if.sv
// Write/read port bundle between the core datapath and gpr_file.
// master = datapath side, slave = register file side.
interface gpr_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              reg_write_en;
  logic              reg_of_en;
  logic              overflow;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              of_flag;
  logic [31:0]       wb_count;

  modport master (
    output reg_write_en, reg_of_en, overflow,
    output waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2, of_flag, wb_count
  );

  modport slave (
    input  reg_write_en, reg_of_en, overflow,
    input  waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2, of_flag, wb_count
  );
endinterface

// File: rtl/gpr_file.sv
// MIPS general-purpose register file with $0 tie-off and ADDI overflow flag.
// Optional same-cycle write->read bypass: define GPR_BYPASS_EN.
module gpr_file
  import gpr_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OF_REG = GPR_IDX_OF
) (
  input logic       clk,
  input logic       rst_n,
  gpr_file_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [31:0]       wb_count_q;
  logic [31:0]       wb_count_d;
  gpr_wq_t           wq;

  // Qualify the incoming write into commit / overflow-set strobes
  always_comb begin
    wq = gpr_write_qual(bus.reg_write_en, bus.reg_of_en,
                        bus.overflow, bus.waddr != '0);
  end

  // Next register state and committed-write count
  always_comb begin
    regs_d = regs_q;
    wb_count_d = wb_count_q;
    if (wq.commit) begin
      regs_d[bus.waddr] = bus.wdata;
    end
    if (wq.of_set) begin
      regs_d[OF_REG][0] = 1'b1;
    end
    regs_d[GPR_IDX_ZERO] = '0;
    if (wq.commit | wq.of_set) begin
      wb_count_d = wb_count_q + 32'd1;
    end
  end

  // Storage and counter, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

`ifdef GPR_BYPASS_EN
  logic byp_ok;
  assign byp_ok = wq.commit & rst_n;
`endif

  // Combinational read ports
  always_comb begin
    bus.rdata1 = '0;
    bus.rdata2 = '0;
    if (bus.raddr1 != '0) begin
      bus.rdata1 = regs_q[bus.raddr1];
    end
    if (bus.raddr2 != '0) begin
      bus.rdata2 = regs_q[bus.raddr2];
    end
`ifdef GPR_BYPASS_EN
    if (byp_ok && bus.raddr1 == bus.waddr) begin
      bus.rdata1 = bus.wdata;
    end
    if (byp_ok && bus.raddr2 == bus.waddr) begin
      bus.rdata2 = bus.wdata;
    end
`endif
  end

  assign bus.of_flag  = regs_q[OF_REG][0];
  assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_gpr_file.sv
// Directed self-checking bench for gpr_file.
// Bypass expectations follow GPR_BYPASS_EN.
module tb_gpr_file;

`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  gpr_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  gpr_file #(.DATA_W(32), .ADDR_W(5), .OF_REG(30)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic put(input logic we, input logic of_en, input logic ovf,
                     input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    bus.reg_write_en = we;
    bus.reg_of_en    = of_en;
    bus.overflow     = ovf;
    bus.waddr        = wa;
    bus.wdata        = wd;
    #1;
  endtask

  task automatic edge_idle();
    @(posedge clk);
    #1;
    bus.reg_write_en = 1'b0;
    bus.reg_of_en    = 1'b0;
    bus.overflow     = 1'b0;
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    put(1'b1, 1'b0, 1'b0, wa, wd);
    edge_idle();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.reg_write_en = 1'b0;
    bus.reg_of_en = 1'b0;
    bus.overflow = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd30;
    #1;
    check("rst_rd1", bus.rdata1, 32'h0);
    check("rst_cnt", bus.wb_count, 32'h0);
    check("rst_of", {31'b0, bus.of_flag}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    wr(5'd5, 32'hDEADBEEF);
    check("r5_load", bus.rdata1, 32'hDEADBEEF);
    check("cnt_r5", bus.wb_count, 32'd1);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rd1", bus.rdata1, 32'h0);
    check("async_cnt", bus.wb_count, 32'h0);

    bus.raddr2 = 5'd12;
    put(1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_00AA);
    check("rstwr_pre", bus.rdata2, 32'h0);
    @(posedge clk);
    #1;
    check("rstwr_lost", bus.wb_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_idle();
    check("rstwr_first", bus.rdata2, 32'h0000_00AA);
    check("rstwr_cnt", bus.wb_count, 32'd1);

    bus.raddr1 = 5'd8;
    put(1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_1234);
    check("r8_same", bus.rdata1, BYP ? 32'h0000_1234 : 32'h0);
    edge_idle();
    check("r8_after", bus.rdata1, 32'h0000_1234);
    check("r8_cnt", bus.wb_count, 32'd2);

    bus.raddr1 = 5'd0;
    wr(5'd0, 32'hFFFF_FFFF);
    check("r0_zero", bus.rdata1, 32'h0);
    check("r0_cnt", bus.wb_count, 32'd2);

    wr(5'd30, 32'h0000_00F0);
    wr(5'd9, 32'h0000_0011);
    bus.raddr1 = 5'd9;
    bus.raddr2 = 5'd30;
    check("pre_of", {31'b0, bus.of_flag}, 32'h0);
    check("pre_cnt", bus.wb_count, 32'd4);
    put(1'b1, 1'b1, 1'b1, 5'd9, 32'h8000_0000);
    check("trap_nobyp", bus.rdata1, 32'h0000_0011);
    edge_idle();
    check("trap_r9", bus.rdata1, 32'h0000_0011);
    check("trap_r30", bus.rdata2, 32'h0000_00F1);
    check("trap_of", {31'b0, bus.of_flag}, 32'h1);
    check("trap_cnt", bus.wb_count, 32'd5);

    put(1'b1, 1'b0, 1'b1, 5'd9, 32'h8000_0000);
    edge_idle();
    check("ign_r9", bus.rdata1, 32'h8000_0000);
    check("ign_r30", bus.rdata2, 32'h0000_00F1);
    check("ign_cnt", bus.wb_count, 32'd6);

    wr(5'd30, 32'h0000_0100);
    check("r30_clr_of", {31'b0, bus.of_flag}, 32'h0);
    put(1'b1, 1'b1, 1'b1, 5'd30, 32'hFFFF_FFFF);
    edge_idle();
    check("trap30_val", bus.rdata2, 32'h0000_0101);
    check("trap30_of", {31'b0, bus.of_flag}, 32'h1);
    check("trap30_cnt", bus.wb_count, 32'd8);

    bus.raddr1 = 5'd10;
    put(1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_0055);
    edge_idle();
    check("addi_ok", bus.rdata1, 32'h0000_0055);
    check("addi_cnt", bus.wb_count, 32'd9);

    bus.raddr1 = 5'd31;
    bus.raddr2 = 5'd31;
    put(1'b1, 1'b1, 1'b1, 5'd31, 32'h0040_3008);
    check("ra_trap_byp", bus.rdata2, 32'h0);
    put(1'b1, 1'b0, 1'b0, 5'd31, 32'h0040_3008);
    check("ra_byp", bus.rdata2, BYP ? 32'h0040_3008 : 32'h0);
    edge_idle();
    check("ra_rd1", bus.rdata1, 32'h0040_3008);
    check("ra_rd2", bus.rdata2, 32'h0040_3008);
    check("ra_cnt", bus.wb_count, 32'd11);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
